// File: rtl/onehot_scan_pkg.sv
// onehot_scan_pkg: shared state and mode encodings for the one-hot scan decoder.
package onehot_scan_pkg;
   typedef enum logic [1:0] {BLANK, DIRECT, SCAN} state_t;
   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: combinational MSB-first one-hot decoder with blanking.
// ONEHOT_SCAN_ACTIVE_LOW_EN inverts the output polarity.
module onehot_dec #(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]      sel_i,
   input  logic                  en_i,
   output logic [2**SEL_W-1:0]   out_o
);
   localparam int OUT_W = 2**SEL_W;
   logic [OUT_W-1:0] oh;
   // OUT_W-1-sel equals ~sel for an unsigned SEL_W-bit index
   assign oh = en_i ? (OUT_W'(1) << ~sel_i) : '0;
`ifdef ONEHOT_SCAN_ACTIVE_LOW_EN
   assign out_o = ~oh;
`else
   assign out_o = oh;
`endif
endmodule

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered one-hot decoder with direct and prescaled scan modes.
// ONEHOT_SCAN_ACTIVE_LOW_EN selects an active-low (inverted) out bus.
module onehot_scan_decoder
   import onehot_scan_pkg::*;
#(
   parameter int SEL_W    = 3,
   parameter int TICK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic                  load,
   output logic [2**SEL_W-1:0]   out,
   output logic [SEL_W-1:0]      idx,
   output logic                  wrap
);
   localparam int OUT_W = 2**SEL_W;
   localparam int PW    = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [SEL_W-1:0] IDX_MAX = '1;
`ifdef ONEHOT_SCAN_ACTIVE_LOW_EN
   localparam logic [OUT_W-1:0] OUT_RST = '1;
`else
   localparam logic [OUT_W-1:0] OUT_RST = '0;
`endif
   state_t           state_q, state_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             wrap_q, wrap_d;
   logic [OUT_W-1:0] out_q, out_d;

   always_comb begin
      state_d = !en ? BLANK : (mode == MODE_SCAN ? SCAN : DIRECT);
      idx_d   = idx_q;
      pre_d   = '0;
      wrap_d  = 1'b0;
      if (state_d == DIRECT) begin
         idx_d = sel;
      end else if (state_d == SCAN) begin
         // entry edge never steps; a load always wins over a due step
         if (load)
            idx_d = sel;
         else if (state_q == SCAN && pre_q == PRE_MAX) begin
            idx_d  = idx_q + 1'b1;
            wrap_d = idx_q == IDX_MAX;
         end else if (state_q == SCAN)
            pre_d = pre_q + 1'b1;
      end
   end

   onehot_dec #(.SEL_W(SEL_W)) u_dec (
      .sel_i (idx_d),
      .en_i  (state_d != BLANK),
      .out_o (out_d)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BLANK;
         idx_q   <= '0;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
         out_q   <= OUT_RST;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pre_q   <= pre_d;
         wrap_q  <= wrap_d;
         out_q   <= out_d;
      end
   end

   assign out  = out_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed checks for direct, scan, load, blank and TICK_DIV=1 behaviour.
module tb_onehot_scan_decoder;
   logic       clk = 1'b0;
   logic       rst_n, en, mode, load;
   logic [2:0] sel;
   logic [7:0] out_a, out_b;
   logic [2:0] idx_a, idx_b;
   logic       wrap_a, wrap_b;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   onehot_scan_decoder #(.SEL_W(3), .TICK_DIV(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
      .out(out_a), .idx(idx_a), .wrap(wrap_a)
   );

   onehot_scan_decoder #(.SEL_W(3), .TICK_DIV(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
      .out(out_b), .idx(idx_b), .wrap(wrap_b)
   );

   function automatic logic [7:0] pol(input logic [7:0] v);
`ifdef ONEHOT_SCAN_ACTIVE_LOW_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; mode = 1'b1; load = 1'b1; sel = 3'd3;
      tick(2);
      chk("rst_out", 32'(out_a), 32'(pol(8'h00)));
      chk("rst_idx", 32'(idx_a), 32'd0);
      chk("rst_wrap", 32'(wrap_a), 32'd0);
      chk("rst_out_b", 32'(out_b), 32'(pol(8'h00)));
      rst_n = 1'b1; load = 1'b0; mode = 1'b0; sel = 3'd5;
      tick(1);
      chk("dir5_out", 32'(out_a), 32'(pol(8'b0000_0100)));
      chk("dir5_idx", 32'(idx_a), 32'd5);
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         tick(1);
         chk("sweep_out", 32'(out_a), 32'(pol(8'h80 >> s)));
         chk("sweep_idx", 32'(idx_a), 32'(s));
      end
      sel = 3'd6;
      tick(1);
      mode = 1'b1; sel = 3'd1;
      tick(1);
      chk("entry_idx", 32'(idx_a), 32'd6);
      chk("entry_idx_b", 32'(idx_b), 32'd6);
      tick(1);
      chk("scan_hold1", 32'(idx_a), 32'd6);
      chk("b_step7", 32'(idx_b), 32'd7);
      tick(1);
      chk("b_wrap_idx", 32'(idx_b), 32'd0);
      chk("b_wrap", 32'(wrap_b), 32'd1);
      chk("b_wrap_out", 32'(out_b), 32'(pol(8'h80)));
      tick(1);
      chk("b_wrap_clr", 32'(wrap_b), 32'd0);
      chk("b_step1", 32'(idx_b), 32'd1);
      chk("scan_hold3", 32'(idx_a), 32'd6);
      tick(1);
      chk("step7_idx", 32'(idx_a), 32'd7);
      chk("step7_out", 32'(out_a), 32'(pol(8'h01)));
      tick(3);
      chk("pre_wrap_idx", 32'(idx_a), 32'd7);
      chk("pre_wrap", 32'(wrap_a), 32'd0);
      tick(1);
      chk("wrap_idx", 32'(idx_a), 32'd0);
      chk("wrap_out", 32'(out_a), 32'(pol(8'h80)));
      chk("wrap_hi", 32'(wrap_a), 32'd1);
      tick(1);
      chk("wrap_lo", 32'(wrap_a), 32'd0);
      tick(2);
      load = 1'b1; sel = 3'd2;
      tick(1);
      load = 1'b0;
      chk("load_idx", 32'(idx_a), 32'd2);
      chk("load_out", 32'(out_a), 32'(pol(8'h20)));
      chk("load_wrap", 32'(wrap_a), 32'd0);
      tick(3);
      chk("load_hold", 32'(idx_a), 32'd2);
      tick(1);
      chk("load_step", 32'(idx_a), 32'd3);
      chk("load_step_out", 32'(out_a), 32'(pol(8'h10)));
      tick(4);
      chk("pre_blank_idx", 32'(idx_a), 32'd4);
      en = 1'b0;
      tick(1);
      chk("blank_out", 32'(out_a), 32'(pol(8'h00)));
      chk("blank_idx", 32'(idx_a), 32'd4);
      tick(9);
      chk("blank10_out", 32'(out_a), 32'(pol(8'h00)));
      chk("blank10_idx", 32'(idx_a), 32'd4);
      en = 1'b1;
      tick(1);
      chk("resume_idx", 32'(idx_a), 32'd4);
      chk("resume_out", 32'(out_a), 32'(pol(8'h08)));
      tick(3);
      chk("resume_hold", 32'(idx_a), 32'd4);
      tick(1);
      chk("resume_step", 32'(idx_a), 32'd5);
      chk("resume_step_out", 32'(out_a), 32'(pol(8'h04)));
      mode = 1'b0; sel = 3'd1; load = 1'b1;
      tick(1);
      chk("to_direct_idx", 32'(idx_a), 32'd1);
      chk("to_direct_out", 32'(out_a), 32'(pol(8'h40)));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
